// File: rtl/keypad_scan_scheduler.sv
// 4x4 keypad scanner: row sequencing, per-key debounce, press/release event FIFO
// and two-player paddle command decode.
module keypad_scan_scheduler #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned DEBOUNCE   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  kp_col,
    output logic [3:0]  kp_row,
    output logic [15:0] key_state,
    output logic        ev_valid,
    output logic [4:0]  ev_data,
    input  logic        ev_ready,
    output logic        ev_overflow,
    output logic        up1,
    output logic        down1,
    output logic        up2,
    output logic        down2
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE - 1);
    localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYC - 1);
    localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StProc   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [1:0]      row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [SetW-1:0] set_q, set_d;
    logic [3:0]      samp_q, samp_d;
    logic [15:0]     ks_q, ks_d;
    logic [CntW-1:0] cnt_q [16];
    logic [CntW-1:0] cnt_d [16];

    logic [4:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      pad_q, pad_d;

    logic       push;
    logic [4:0] push_data;
    logic [3:0] key_idx;
    logic       pop;
    logic       full;
    logic       accept;

    assign key_idx = {row_q, col_q};

    // Scan sequencer and debounce of the key addressed by {row, col} during PROC.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        set_d     = set_q;
        samp_d    = samp_q;
        ks_d      = ks_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = 5'd0;
        case (state_q)
            StIdle: begin
                if (scan_en) begin
                    state_d = StSettle;
                    row_d   = 2'd0;
                    set_d   = '0;
                end
            end
            StSettle: begin
                if (set_q == SetLast) begin
                    state_d = StSample;
                end else begin
                    set_d = set_q + SetW'(1);
                end
            end
            StSample: begin
                samp_d  = ~kp_col;
                col_d   = 2'd0;
                state_d = StProc;
            end
            StProc: begin
                if (samp_q[col_q] == ks_q[key_idx]) begin
                    cnt_d[key_idx] = '0;
                end else if (cnt_q[key_idx] == DebLast) begin
                    ks_d[key_idx]  = ~ks_q[key_idx];
                    cnt_d[key_idx] = '0;
                    push           = 1'b1;
                    push_data      = {~ks_q[key_idx], key_idx};
                end else begin
                    cnt_d[key_idx] = cnt_q[key_idx] + CntW'(1);
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    row_d   = row_q + 2'd1;
                    set_d   = '0;
                    state_d = scan_en ? StSettle : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop    = (occ_q != '0) && ev_ready;
        full   = (occ_q == OccFull);
        accept = push && (!full || pop);
        wr_d   = accept ? wr_q + PtrW'(1) : wr_q;
        rd_d   = pop ? rd_q + PtrW'(1) : rd_q;
        occ_d  = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (pop && !accept) begin
            occ_d = occ_q - OccW'(1);
        end
        ovf_d = ovf_q | (push & full & ~pop);
        pad_d = {ks_q[7] & ~ks_q[3], ks_q[3] & ~ks_q[7],
                 ks_q[4] & ~ks_q[0], ks_q[0] & ~ks_q[4]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            set_q   <= '0;
            samp_q  <= 4'd0;
            ks_q    <= 16'd0;
            cnt_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            pad_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            set_q   <= set_d;
            samp_q  <= samp_d;
            ks_q    <= ks_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            pad_q   <= pad_d;
        end
    end

    // Event storage needs no reset; the occupancy count guards every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_q] <= push_data;
        end
    end

    assign kp_row      = (state_q == StIdle) ? 4'b1111 : ~(4'b0001 << row_q);
    assign key_state   = ks_q;
    assign ev_valid    = (occ_q != '0);
    assign ev_data     = fifo_q[rd_q];
    assign ev_overflow = ovf_q;
    assign up1         = pad_q[3];
    assign down1       = pad_q[2];
    assign up2         = pad_q[1];
    assign down2       = pad_q[0];

endmodule
